// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared types and constants for the arithmetic datapath (addsub, seq_divider).
//   divState_t        : divider control state, IDLE or RUN
//   DIV_WIDTH_DEFAULT : default operand width of the divider
//   countWidth()      : width of the iteration counter for a given operand width
// ---------------------------------------------------------------------------
package arith_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } divState_t;

  // Counter only has to reach WIDTH-1; keep at least one bit so tiny widths
  // still produce a legal vector.
  function automatic int countWidth(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem_in   in  WIDTH  partial remainder before the step (always < divisor)
//   next_bit in  1      next dividend bit shifted into the remainder
//   divisor  in  WIDTH  divisor (non-zero whenever the result is used)
//   rem_out  out WIDTH  partial remainder after the step
//   q_bit    out 1      quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  // Because rem_in < divisor, the shifted value is below 2*divisor, so the
  // WIDTH+1 bit difference never overflows and its MSB is a true sign bit.
  assign w_shifted = {rem_in, next_bit};
  assign w_trial   = w_shifted - {1'b0, divisor};
  assign q_bit     = ~w_trial[WIDTH];

  // Non-negative trial is kept; otherwise the shifted value is restored.
  // Either result fits in WIDTH bits.
  assign rem_out   = q_bit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk          in  1      rising-edge clock
//   rst_n        in  1      asynchronous active-low reset
//   start        in  1      request, sampled only while busy=0
//   dividend     in  WIDTH  unsigned dividend, captured on accept
//   divisor      in  WIDTH  unsigned divisor, captured on accept
//   busy         out 1      operation in progress
//   done         out 1      one-cycle pulse, results valid
//   quotient     out WIDTH  held until the next done
//   remainder    out WIDTH  held until the next done
//   div_by_zero  out 1      held with the results
// ---------------------------------------------------------------------------
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CNT_W      = countWidth(WIDTH);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  divState_t        r_state;
  divState_t        w_nextState;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_divByZero;
  logic             r_done;

  logic             w_accept;
  logic             w_finish;
  logic             w_zeroDiv;
  logic [WIDTH-1:0] w_stepRem;
  logic             w_qBit;

  // The partial remainder and the remaining dividend bits shift as one
  // {rem,dvd} pair; quotient bits enter at the bottom of r_dvd, so after
  // the last step r_dvd holds the full quotient.
  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in   (r_rem),
    .next_bit (r_dvd[WIDTH-1]),
    .divisor  (r_divisor),
    .rem_out  (w_stepRem),
    .q_bit    (w_qBit)
  );

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and control decode. A zero divisor finishes on the first
  // RUN cycle without iterating; otherwise the last step is count==WIDTH-1.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_zeroDiv   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (r_divisor == '0) begin
          w_zeroDiv   = 1'b1;
          w_finish    = 1'b1;
          w_nextState = IDLE;
        end else if (r_count == LAST_COUNT) begin
          w_finish    = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath. Result registers load only on the finishing edge, so a new
  // accept leaves the previous results visible until its own done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divByZero <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_dvd     <= dividend;
        r_divisor <= divisor;
        r_rem     <= '0;
        r_count   <= '0;
      end else if (r_state == RUN) begin
        if (w_zeroDiv) begin
          // r_dvd has not been shifted yet, so it is still the dividend.
          r_quotient  <= '1;
          r_remainder <= r_dvd;
          r_divByZero <= 1'b1;
          r_done      <= 1'b1;
        end else begin
          r_rem   <= w_stepRem;
          r_dvd   <= {r_dvd[WIDTH-2:0], w_qBit};
          r_count <= r_count + CNT_W'(1);
          if (w_finish) begin
            r_quotient  <= {r_dvd[WIDTH-2:0], w_qBit};
            r_remainder <= w_stepRem;
            r_divByZero <= 1'b0;
            r_done      <= 1'b1;
          end
        end
      end
    end
  end

  assign busy        = (r_state == RUN);
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_divByZero;

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (WIDTH=8): directed operations with
// hand-computed results plus a cycle-level reference model of the handshake.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W       = 8;
  localparam int TIMEOUT = 40;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         start    = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor  = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 1'b0;

  // Reference model state: a pending operation counts down the cycles left
  // until its result must appear; the result itself comes from / and %.
  bit         mBusy = 1'b0;
  bit         mDone = 1'b0;
  logic [W-1:0] mQ  = '0;
  logic [W-1:0] mR  = '0;
  bit         mZ    = 1'b0;
  int         mLeft = 0;
  logic [W-1:0] pA  = '0;
  logic [W-1:0] pB  = '0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Cycle-level model of the accept/latency/hold behaviour.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy <= 1'b0;
      mDone <= 1'b0;
      mQ    <= '0;
      mR    <= '0;
      mZ    <= 1'b0;
      mLeft <= 0;
    end else begin
      mDone <= 1'b0;
      if (mBusy) begin
        if (mLeft == 1) begin
          mBusy <= 1'b0;
          mDone <= 1'b1;
          if (pB == 0) begin
            mQ <= '1;
            mR <= pA;
            mZ <= 1'b1;
          end else begin
            mQ <= pA / pB;
            mR <= pA % pB;
            mZ <= 1'b0;
          end
        end
        mLeft <= mLeft - 1;
      end else if (start) begin
        pA    <= dividend;
        pB    <= divisor;
        mLeft <= (divisor == 0) ? 1 : W;
        mBusy <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, away from the rising edge, all outputs must match the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy",        int'(busy),        int'(mBusy));
      checkOutput("done",        int'(done),        int'(mDone));
      checkOutput("quotient",    int'(quotient),    int'(mQ));
      checkOutput("remainder",   int'(remainder),   int'(mR));
      checkOutput("div_by_zero", int'(div_by_zero), int'(mZ));
    end
  end

  // Drive a request so it is accepted on the next rising edge (E0).
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count rising edges until done is seen; an expired bound is a failure.
  task automatic waitDone(output int edges);
    edges = 0;
    while (1) begin
      @(posedge clk);
      edges++;
      #1;
      if (done) break;
      if (edges >= TIMEOUT) begin
        checkOutput("done_timeout", edges, -1);
        break;
      end
    end
  endtask

  task automatic runDirected(input string name, input logic [W-1:0] a,
                             input logic [W-1:0] b, input int expEdges,
                             input int expQ, input int expR, input int expZ);
    int edges;
    applyStimulus(a, b);
    waitDone(edges);
    checkOutput({name, "_latency"}, edges, expEdges);
    checkOutput({name, "_q"}, int'(quotient), expQ);
    checkOutput({name, "_r"}, int'(remainder), expR);
    checkOutput({name, "_dbz"}, int'(div_by_zero), expZ);
    checkOutput({name, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int edges;
    logic [W-1:0] a;
    logic [W-1:0] b;

    // Reset state.
    repeat (3) @(posedge clk);
    checkEn = 1'b1;
    #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_q", int'(quotient), 0);
    checkOutput("rst_r", int'(remainder), 0);
    checkOutput("rst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic directed cases.
    runDirected("100div7", 8'd100, 8'd7, 8, 14, 2, 0);
    runDirected("255div1", 8'd255, 8'd1, 8, 255, 0, 0);
    runDirected("5div9",   8'd5,   8'd9, 8, 0, 5, 0);
    runDirected("0div3",   8'd0,   8'd3, 8, 0, 0, 0);
    runDirected("42div0",  8'd42,  8'd0, 1, 255, 42, 1);
    runDirected("255div255", 8'd255, 8'd255, 8, 1, 0, 0);

    // start pulsed at E3 with other operands while running 200/13.
    applyStimulus(8'd200, 8'd13);
    repeat (2) @(posedge clk);
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(edges);
    checkOutput("ignore_latency", edges + 3, 8);
    checkOutput("ignore_q", int'(quotient), 15);
    checkOutput("ignore_r", int'(remainder), 5);

    // Back-to-back: start held during the done cycle.
    applyStimulus(8'd200, 8'd13);
    waitDone(edges);
    checkOutput("b2b_first_q", int'(quotient), 15);
    dividend = 8'd9;
    divisor  = 8'd2;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("b2b_busy", int'(busy), 1);
    checkOutput("b2b_held_r", int'(remainder), 5);
    waitDone(edges);
    checkOutput("b2b_latency", edges, 8);
    checkOutput("b2b_q", int'(quotient), 4);
    checkOutput("b2b_r", int'(remainder), 1);

    // Reset asserted at E4 of a running operation.
    applyStimulus(8'd100, 8'd7);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_q", int'(quotient), 0);
    checkOutput("abort_r", int'(remainder), 0);
    @(negedge clk);
    rst_n = 1'b1;
    runDirected("after_abort", 8'd100, 8'd7, 8, 14, 2, 0);

    // Random sweep with algebraic checks; the per-cycle model checks the rest.
    for (int i = 0; i < 300; i++) begin
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : W'($urandom_range(1, 255));
      applyStimulus(a, b);
      waitDone(edges);
      if (b == 0) begin
        checkOutput("rand_dbz_latency", edges, 1);
        checkOutput("rand_dbz_r", int'(remainder), int'(a));
      end else begin
        checkOutput("rand_latency", edges, 8);
        checkOutput("rand_identity", int'(quotient) * int'(b) + int'(remainder), int'(a));
        checkOutput("rand_r_lt_d", int'(remainder < b), 1);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
